// File: rtl/cp0_regs.sv
// cp0_regs -- MIPS coprocessor-0 register block.
//
// Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14)
// and PRId(15). Registers MTC0 writes from WB, records exception entry and
// ERET, runs the Count/Compare timer and raises the interrupt request.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cp_read_en/addr/data          combinational read port (data = 0 when idle)
//   cp_write_en/addr/data         MTC0 commit from WB
//   exc_valid/code/epc/bd         exception commit
//   exc_badvaddr_valid/badvaddr   faulting address for address exceptions
//   eret                          ERET commit
//   hw_int                        level-sensitive external interrupts
//   status_o/cause_o/epc_o        current register values
//   int_pending                   interrupt should be taken
module cp0_regs #(
    parameter logic [31:0] PRID_VALUE = 32'h0001_8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cp_read_en,
    input  logic [4:0]  cp_read_addr,
    output logic [31:0] cp_read_data,
    input  logic        cp_write_en,
    input  logic [4:0]  cp_write_addr,
    input  logic [31:0] cp_write_data,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_epc,
    input  logic        exc_bd,
    input  logic        exc_badvaddr_valid,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        int_pending
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_epc;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic        r_ti;
    logic [5:0]  r_ip_hw;   // Cause.IP[7:2], resampled every cycle
    logic [1:0]  r_ip_sw;   // Cause.IP[1:0], software interrupts
    logic [4:0]  r_exccode;
    logic        r_tick;

    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic [31:0] w_status;
    logic [31:0] w_cause;

    assign w_wr_count   = cp_write_en && (cp_write_addr == REG_COUNT);
    assign w_wr_compare = cp_write_en && (cp_write_addr == REG_COMPARE);
    assign w_wr_status  = cp_write_en && (cp_write_addr == REG_STATUS);
    assign w_wr_cause   = cp_write_en && (cp_write_addr == REG_CAUSE);
    assign w_wr_epc     = cp_write_en && (cp_write_addr == REG_EPC);

    // BEV (bit 22) is hardwired to 1.
    assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause  = {r_bd, r_ti, 14'd0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_badvaddr <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_epc      <= '0;
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ti       <= 1'b0;
            r_ip_hw    <= '0;
            r_ip_sw    <= '0;
            r_exccode  <= '0;
            r_tick     <= 1'b0;
        end else begin
            // Count advances every second clock; an MTC0 load replaces the
            // increment but the tick phase keeps running.
            r_tick <= ~r_tick;
            if (w_wr_count)
                r_count <= cp_write_data;
            else if (r_tick)
                r_count <= r_count + 32'd1;

            if (w_wr_compare)
                r_compare <= cp_write_data;

            // Writing Compare acknowledges the timer; the clear wins over a
            // coincident match.
            if (w_wr_compare)
                r_ti <= 1'b0;
            else if (r_count == r_compare)
                r_ti <= 1'b1;

            // Timer interrupt shares IP7 with hw_int[5].
            r_ip_hw <= {hw_int[5] | r_ti, hw_int[4:0]};

            if (w_wr_cause)
                r_ip_sw <= cp_write_data[9:8];

            if (w_wr_status) begin
                r_im <= cp_write_data[15:8];
                r_ie <= cp_write_data[0];
            end

            // Exception beats ERET beats MTC0 on EXL/EPC/BD/ExcCode.
            if (exc_valid) begin
                // Nested exception keeps the original return point.
                if (!r_exl) begin
                    r_epc <= exc_epc;
                    r_bd  <= exc_bd;
                end
                r_exl     <= 1'b1;
                r_exccode <= exc_code;
                if (exc_badvaddr_valid)
                    r_badvaddr <= exc_badvaddr;
            end else begin
                if (eret)
                    r_exl <= 1'b0;
                else if (w_wr_status)
                    r_exl <= cp_write_data[1];
                if (w_wr_epc)
                    r_epc <= cp_write_data;
            end
        end
    end

    always_comb begin
        cp_read_data = '0;
        if (cp_read_en) begin
            case (cp_read_addr)
                REG_BADVADDR: cp_read_data = r_badvaddr;
                REG_COUNT:    cp_read_data = r_count;
                REG_COMPARE:  cp_read_data = r_compare;
                REG_STATUS:   cp_read_data = w_status;
                REG_CAUSE:    cp_read_data = w_cause;
                REG_EPC:      cp_read_data = r_epc;
                REG_PRID:     cp_read_data = PRID_VALUE;
                default:      cp_read_data = '0;
            endcase
        end
    end

    assign status_o    = w_status;
    assign cause_o     = w_cause;
    assign epc_o       = r_epc;
    assign int_pending = r_ie & ~r_exl & (|({r_ip_hw, r_ip_sw} & r_im));

endmodule

// File: tb/tb_cp0_regs.sv
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cp_read_en = 1'b0;
    logic [4:0]  cp_read_addr = '0;
    logic [31:0] cp_read_data;
    logic        cp_write_en = 1'b0;
    logic [4:0]  cp_write_addr = '0;
    logic [31:0] cp_write_data = '0;
    logic        exc_valid = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] exc_epc = '0;
    logic        exc_bd = 1'b0;
    logic        exc_badvaddr_valid = 1'b0;
    logic [31:0] exc_badvaddr = '0;
    logic        eret = 1'b0;
    logic [5:0]  hw_int = '0;
    logic [31:0] status_o, cause_o, epc_o;
    logic        int_pending;

    int total = 0;
    int bad = 0;

    cp0_regs dut (
        .clk(clk), .rst_n(rst_n),
        .cp_read_en(cp_read_en), .cp_read_addr(cp_read_addr), .cp_read_data(cp_read_data),
        .cp_write_en(cp_write_en), .cp_write_addr(cp_write_addr), .cp_write_data(cp_write_data),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
        .exc_badvaddr_valid(exc_badvaddr_valid), .exc_badvaddr(exc_badvaddr),
        .eret(eret), .hw_int(hw_int),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        cp_read_en = 1'b1;
        cp_read_addr = a;
        #1;
        v = cp_read_data;
        cp_read_en = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp_write_en = 1'b1;
        cp_write_addr = a;
        cp_write_data = d;
        step();
        cp_write_en = 1'b0;
    endtask

    task automatic exc(input logic [31:0] epc, input logic bd, input logic [4:0] code,
                       input logic bv, input logic [31:0] bva);
        exc_valid = 1'b1;
        exc_epc = epc;
        exc_bd = bd;
        exc_code = code;
        exc_badvaddr_valid = bv;
        exc_badvaddr = bva;
        step();
        exc_valid = 1'b0;
        exc_badvaddr_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] prev;
        int n;

        // Reset values, sampled after release but before any clock edge.
        #12;
        rst_n = 1'b1;
        #1;
        rd(5'd12, v); chk("rst_status", v, 32'h0040_0000);
        rd(5'd13, v); chk("rst_cause", v, 32'h0);
        rd(5'd14, v); chk("rst_epc", v, 32'h0);
        rd(5'd15, v); chk("rst_prid", v, 32'h0001_8000);
        chk("rst_intp", {31'd0, int_pending}, 32'd0);

        // Count == Compare == 0 raises TI on the first edge.
        step();
        chk("ti_after_rst", {31'd0, cause_o[30]}, 32'd1);
        mtc0(5'd11, 32'h0000_1000);
        step();
        chk("ti_cleared", cause_o, 32'h0);

        // Write masks.
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, v); chk("status_mask", v, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, v); chk("cause_mask", v, 32'h0000_0300);
        chk("intp_exl_blocks", {31'd0, int_pending}, 32'd0);
        mtc0(5'd12, 32'h0000_FF01);
        chk("intp_sw", {31'd0, int_pending}, 32'd1);
        mtc0(5'd13, 32'h0);
        mtc0(5'd12, 32'h0);
        chk("intp_off", {31'd0, int_pending}, 32'd0);

        // Idle read port and unmapped registers read 0.
        cp_read_en = 1'b0; cp_read_addr = 5'd12; #1;
        chk("rd_disabled", cp_read_data, 32'h0);
        mtc0(5'd3, 32'hDEAD_BEEF);
        rd(5'd3, v); chk("rd_unmapped", v, 32'h0);

        // Timer: TI 20-21 edges after Count is loaded with 0, Compare = 10.
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'h0);
        n = 0;
        while (!cause_o[30] && n < 40) begin
            step();
            n++;
        end
        chk("ti_latency", {31'd0, (n == 20 || n == 21)}, 32'd1);
        step();
        chk("ip7_follows_ti", {31'd0, cause_o[15]}, 32'd1);
        mtc0(5'd11, 32'd100);
        chk("ti_clr_cmp", {31'd0, cause_o[30]}, 32'd0);
        step();
        step();
        chk("ip7_clr", {31'd0, cause_o[15]}, 32'd0);

        // Exception entry and nested exception.
        exc(32'hBFC0_0100, 1'b1, 5'd4, 1'b1, 32'h0000_1003);
        chk("exc_epc", epc_o, 32'hBFC0_0100);
        chk("exc_cause", cause_o, 32'h8000_0010);
        chk("exc_exl", {31'd0, status_o[1]}, 32'd1);
        rd(5'd8, v); chk("exc_badva", v, 32'h0000_1003);
        exc(32'h0000_0200, 1'b0, 5'd5, 1'b0, 32'h0000_7777);
        chk("nest_epc", epc_o, 32'hBFC0_0100);
        chk("nest_cause", cause_o, 32'h8000_0014);
        rd(5'd8, v); chk("nest_badva", v, 32'h0000_1003);
        eret = 1'b1; step(); eret = 1'b0;
        chk("eret_exl", {31'd0, status_o[1]}, 32'd0);

        // exc_valid + eret + MTC0 EPC in one cycle: exception wins.
        eret = 1'b1;
        cp_write_en = 1'b1; cp_write_addr = 5'd14; cp_write_data = 32'h0000_1234;
        exc(32'h0000_0300, 1'b0, 5'd8, 1'b0, 32'h0);
        eret = 1'b0; cp_write_en = 1'b0;
        chk("prio_exl", {31'd0, status_o[1]}, 32'd1);
        chk("prio_epc", epc_o, 32'h0000_0300);
        chk("prio_cause", cause_o, 32'h0000_0020);
        eret = 1'b1; step(); eret = 1'b0;
        chk("prio_eret", {31'd0, status_o[1]}, 32'd0);
        mtc0(5'd14, 32'h0000_1234);
        chk("epc_mtc0", epc_o, 32'h0000_1234);

        // Count wrap: FFFF_FFFE -> FFFF_FFFF -> 0, one tick (2 edges) apart.
        mtc0(5'd9, 32'hFFFF_FFFE);
        rd(5'd9, v); chk("cnt_load", v, 32'hFFFF_FFFE);
        prev = v;
        n = 0;
        while (v == prev && n < 4) begin step(); n++; rd(5'd9, v); end
        chk("cnt_ff", v, 32'hFFFF_FFFF);
        prev = v;
        n = 0;
        while (v == prev && n < 4) begin step(); n++; rd(5'd9, v); end
        chk("cnt_wrap", v, 32'h0);
        chk("cnt_wrap_gap", n, 32'd2);

        // Asynchronous reset mid-operation.
        mtc0(5'd12, 32'h0000_FF03);
        hw_int = 6'h3F;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_status", status_o, 32'h0040_0000);
        chk("arst_cause", cause_o, 32'h0);
        chk("arst_epc", epc_o, 32'h0);
        chk("arst_intp", {31'd0, int_pending}, 32'd0);
        rd(5'd9, v); chk("arst_count", v, 32'h0);
        rd(5'd11, v); chk("arst_compare", v, 32'h0);
        rd(5'd8, v); chk("arst_badva", v, 32'h0);
        hw_int = '0;
        step();
        rst_n = 1'b1;
        #1;
        // Count first increments on the 2nd edge after release.
        step();
        rd(5'd9, v); chk("post_rst_e1", v, 32'h0);
        step();
        rd(5'd9, v); chk("post_rst_e2", v, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
